// File: rtl/seven_seg_capture.sv
// rtl/seven_seg_capture.sv - capture side of a scanned 3-digit common-anode seven-segment display
// Rebuilds the displayed 12-bit hex value from snooped digit selects and segment lines.
module seven_seg_capture #(
  parameter int SETTLE_CYCLES   = 64,
  parameter int TIMEOUT_CYCLES  = 2000000,
  parameter bit SEG_ACTIVE_HIGH = 1'b1
) (
  input  logic        clk_25mhz,
  input  logic        resetn,
  input  logic [2:0]  ca,
  input  logic [6:0]  seg,
  output logic [11:0] value,
  output logic        valid,
  output logic        bad_pattern,
  output logic [7:0]  err_count,
  output logic        stale
);

  localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_PRE  = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HELD} state_t;

  logic [2:0]    r_ca_s1, r_ca_s2, r_ca_prev;
  logic [6:0]    r_seg_s1, r_seg_s2, r_seg_prev;
  state_t        r_state;
  logic [SW-1:0] r_settle;
  logic [TW-1:0] r_tcnt;
  logic [2:0]    r_mask;
  logic [3:0]    r_shadow [3];

  logic [6:0]    w_seg_lit;
  logic [3:0]    w_nib;
  logic          w_nib_ok;
  logic          w_ca_legal;
  logic [1:0]    w_digit;
  logic [2:0]    w_digit_bit;
  logic          w_ca_chg, w_chg;
  logic          w_sample, w_frame_done;
  logic [3:0]    w_new0, w_new1, w_new2;

  always_ff @(posedge clk_25mhz) begin
    if (!resetn) begin
      r_ca_s1    <= 3'b111;
      r_ca_s2    <= 3'b111;
      r_ca_prev  <= 3'b111;
      r_seg_s1   <= 7'h00;
      r_seg_s2   <= 7'h00;
      r_seg_prev <= 7'h00;
    end else begin
      r_ca_s1    <= ca;
      r_ca_s2    <= r_ca_s1;
      r_ca_prev  <= r_ca_s2;
      r_seg_s1   <= seg;
      r_seg_s2   <= r_seg_s1;
      r_seg_prev <= r_seg_s2;
    end
  end

  assign w_seg_lit = SEG_ACTIVE_HIGH ? r_seg_s2 : ~r_seg_s2;

  always_comb begin
    w_nib    = 4'h0;
    w_nib_ok = 1'b1;
    case (w_seg_lit)
      7'h3F: w_nib = 4'h0;
      7'h06: w_nib = 4'h1;
      7'h5B: w_nib = 4'h2;
      7'h4F: w_nib = 4'h3;
      7'h66: w_nib = 4'h4;
      7'h6D: w_nib = 4'h5;
      7'h7D: w_nib = 4'h6;
      7'h07: w_nib = 4'h7;
      7'h7F: w_nib = 4'h8;
      7'h6F: w_nib = 4'h9;
      7'h77: w_nib = 4'hA;
      7'h7C: w_nib = 4'hB;
      7'h39: w_nib = 4'hC;
      7'h5E: w_nib = 4'hD;
      7'h79: w_nib = 4'hE;
      7'h71: w_nib = 4'hF;
      default: w_nib_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_ca_legal = 1'b1;
    w_digit    = 2'd0;
    case (r_ca_s2)
      3'b110:  w_digit = 2'd0;
      3'b101:  w_digit = 2'd1;
      3'b011:  w_digit = 2'd2;
      default: w_ca_legal = 1'b0;
    endcase
  end

  assign w_digit_bit  = 3'b001 << w_digit;
  assign w_ca_chg     = (r_ca_s2 != r_ca_prev);
  assign w_chg        = w_ca_chg || (r_seg_s2 != r_seg_prev);
  assign w_sample     = (r_state == S_SETTLE) && w_ca_legal && !w_chg && (r_settle == SETTLE_LAST);
  assign w_frame_done = w_sample && w_nib_ok && ((r_mask | w_digit_bit) == 3'b111);

  // The published value must include the nibble being sampled this very cycle.
  assign w_new0 = (w_digit == 2'd0) ? w_nib : r_shadow[0];
  assign w_new1 = (w_digit == 2'd1) ? w_nib : r_shadow[1];
  assign w_new2 = (w_digit == 2'd2) ? w_nib : r_shadow[2];

  always_ff @(posedge clk_25mhz) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_settle    <= '0;
      r_tcnt      <= '0;
      r_mask      <= 3'b000;
      r_shadow[0] <= 4'h0;
      r_shadow[1] <= 4'h0;
      r_shadow[2] <= 4'h0;
      value       <= 12'h000;
      valid       <= 1'b0;
      bad_pattern <= 1'b0;
      err_count   <= 8'd0;
      stale       <= 1'b0;
    end else begin
      valid       <= 1'b0;
      bad_pattern <= 1'b0;

      case (r_state)
        S_IDLE: begin
          r_settle <= '0;
          if (w_ca_legal) r_state <= S_SETTLE;
        end
        S_SETTLE: begin
          if (!w_ca_legal) begin
            r_state  <= S_IDLE;
            r_settle <= '0;
          end else if (w_chg) begin
            r_settle <= '0;
          end else if (r_settle == SETTLE_LAST) begin
            r_state  <= S_HELD;
            r_settle <= '0;
          end else begin
            r_settle <= r_settle + 1'b1;
          end
        end
        S_HELD: begin
          r_settle <= '0;
          if (w_ca_chg) r_state <= w_ca_legal ? S_SETTLE : S_IDLE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_settle <= '0;
        end
      endcase

      if (w_sample) begin
        if (w_nib_ok) begin
          r_shadow[w_digit] <= w_nib;
          if (w_frame_done) begin
            value  <= {w_new2, w_new1, w_new0};
            valid  <= 1'b1;
            r_mask <= 3'b000;
          end else begin
            r_mask <= r_mask | w_digit_bit;
          end
        end else begin
          bad_pattern <= 1'b1;
          r_mask      <= 3'b000;
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
      end

      if (w_frame_done) begin
        r_tcnt <= '0;
        stale  <= 1'b0;
      end else if (r_tcnt != TIMEOUT_MAX) begin
        r_tcnt <= r_tcnt + 1'b1;
        if (r_tcnt == TIMEOUT_PRE) stale <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// tb/tb_seven_seg_capture.sv - directed bench for seven_seg_capture, active-high and inverted-segment instances
`timescale 1ns/1ps
module tb_seven_seg_capture;

  localparam int TMO = 5000;

  logic        clk = 1'b0;
  logic        resetn;
  logic [2:0]  ca;
  logic [6:0]  seg;
  logic [6:0]  seg_n;
  logic [11:0] value_h, value_n;
  logic        valid_h, valid_n, badp_h, badp_n, stale_h, stale_n;
  logic [7:0]  err_h, err_n;

  always #20 clk = ~clk;
  assign seg_n = ~seg;

  seven_seg_capture #(.SETTLE_CYCLES(64), .TIMEOUT_CYCLES(TMO), .SEG_ACTIVE_HIGH(1'b1)) u_dut (
    .clk_25mhz(clk), .resetn(resetn), .ca(ca), .seg(seg),
    .value(value_h), .valid(valid_h), .bad_pattern(badp_h), .err_count(err_h), .stale(stale_h)
  );

  seven_seg_capture #(.SETTLE_CYCLES(64), .TIMEOUT_CYCLES(TMO), .SEG_ACTIVE_HIGH(1'b0)) u_dut_n (
    .clk_25mhz(clk), .resetn(resetn), .ca(ca), .seg(seg_n),
    .value(value_n), .valid(valid_n), .bad_pattern(badp_n), .err_count(err_n), .stale(stale_n)
  );

  int total = 0;
  int bad   = 0;
  int nv_h = 0, nv_n = 0, nb_h = 0, nb_n = 0;
  int bv_h = 0, bv_n = 0, bb_h = 0, bb_n = 0;
  logic [6:0] font [16];

  always @(negedge clk) begin
    if (valid_h) nv_h++;
    if (valid_n) nv_n++;
    if (badp_h)  nb_h++;
    if (badp_n)  nb_n++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic mark();
    bv_h = nv_h; bv_n = nv_n; bb_h = nb_h; bb_n = nb_n;
  endtask

  task automatic chk_all(input string tag, input logic [11:0] v, input int dv, input int db);
    chk({tag, "_value_h"}, 32'(value_h), 32'(v));
    chk({tag, "_value_n"}, 32'(value_n), 32'(v));
    chk({tag, "_nvalid_h"}, 32'(nv_h - bv_h), 32'(dv));
    chk({tag, "_nvalid_n"}, 32'(nv_n - bv_n), 32'(dv));
    chk({tag, "_nbad_h"}, 32'(nb_h - bb_h), 32'(db));
    chk({tag, "_nbad_n"}, 32'(nb_n - bb_n), 32'(db));
  endtask

  task automatic digit(input int d, input logic [6:0] s, input int dwell);
    ca  = (d == 0) ? 3'b110 : (d == 1) ? 3'b101 : 3'b011;
    seg = s;
    cyc(dwell);
  endtask

  task automatic scan(input logic [11:0] v, input int dwell, input int blank);
    for (int d = 0; d < 3; d++) begin
      digit(d, font[v[4*d +: 4]], dwell);
      if (blank > 0) begin
        ca = 3'b111;
        cyc(blank);
      end
    end
  endtask

  task automatic rotate(input logic [11:0] v, input int n, input int dwell);
    int el = 0;
    int d  = 0;
    while (el < n) begin
      digit(d, font[v[4*d +: 4]], dwell);
      el += dwell;
      d = (d + 1) % 3;
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    ca     = 3'b111;
    seg    = 7'h00;
    cyc(5);
    resetn = 1'b1;
    cyc(2);
  endtask

  initial begin
    font = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    resetn = 1'b0;
    ca     = 3'b111;
    seg    = 7'h00;

    // reset state
    do_reset();
    chk("rst_value", 32'(value_h), 0);
    chk("rst_valid", 32'(valid_h), 0);
    chk("rst_bad", 32'(badp_h), 0);
    chk("rst_err_h", 32'(err_h), 0);
    chk("rst_err_n", 32'(err_n), 0);
    chk("rst_stale", 32'(stale_h), 0);

    // plain scan of 0x1A7
    mark();
    scan(12'h1A7, 1000, 0);
    chk_all("t1", 12'h1A7, 1, 0);

    // scan with blanking between digits
    do_reset();
    mark();
    scan(12'h1A7, 1000, 400);
    chk_all("t2", 12'h1A7, 1, 0);

    // dwell too short to settle, then timeout, then recovery
    do_reset();
    mark();
    rotate(12'h123, 4740, 30);
    chk("t3_stale_early_h", 32'(stale_h), 0);
    chk("t3_stale_early_n", 32'(stale_n), 0);
    rotate(12'h123, 420, 30);
    chk("t3_stale_late_h", 32'(stale_h), 1);
    chk("t3_stale_late_n", 32'(stale_n), 1);
    chk_all("t3_short", 12'h000, 0, 0);
    mark();
    scan(12'hF00, 1000, 0);
    chk_all("t3_rec", 12'hF00, 1, 0);
    chk("t3_stale_clr_h", 32'(stale_h), 0);
    chk("t3_stale_clr_n", 32'(stale_n), 0);

    // invalid digit1 discards the partial frame
    do_reset();
    mark();
    digit(0, font[3], 1000);
    digit(1, 7'h00, 1000);
    chk_all("t4_badseg", 12'h000, 0, 1);
    chk("t4_err_h", 32'(err_h), 1);
    chk("t4_err_n", 32'(err_n), 1);
    digit(2, font[5], 1000);
    digit(0, font[3], 1000);
    chk_all("t4_partial", 12'h000, 0, 1);
    digit(1, font[14], 1000);
    chk_all("t4_done", 12'h5E3, 1, 1);

    // error counter saturation
    mark();
    for (int i = 0; i < 300; i++) digit(i % 2, 7'h00, 80);
    chk("t5_err_h", 32'(err_h), 255);
    chk("t5_err_n", 32'(err_n), 255);
    chk_all("t5_bad", 12'h5E3, 0, 300);
    chk("t5_stale_h", 32'(stale_h), 1);
    mark();
    scan(12'hC9D, 1000, 0);
    chk_all("t5_scan", 12'hC9D, 1, 0);
    chk("t5_err_hold", 32'(err_h), 255);
    chk("t5_stale_clr", 32'(stale_h), 0);

    // reset between captures discards partial digits
    do_reset();
    mark();
    digit(2, font[3], 1000);
    digit(1, font[12], 1000);
    do_reset();
    digit(0, font[5], 1000);
    chk_all("t6_partial", 12'h000, 0, 0);
    scan(12'h3C5, 1000, 0);
    chk_all("t6_full", 12'h3C5, 1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
